// File: rtl/ring_johnson_counter.sv
// rtl/ring_johnson_counter.sv - parametrised ring/Johnson counter with tc, wrap count and illegal flag
// Optional feature macro: RING_SELF_CORRECT_EN (illegal states snap to the mode seed on an enabled step)
module ring_johnson_counter #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              illegal
);

`ifdef RING_SELF_CORRECT_EN
  localparam bit SELF_CORRECT = 1'b1;
`else
  localparam bit SELF_CORRECT = 1'b0;
`endif

  logic             mode_q;
  logic             mode_change;
  logic [WIDTH-1:0] seed_cur;
  logic [WIDTH-1:0] seed_new;
  logic [WIDTH-1:0] nxt;
  logic             step_tc;
  logic             ring_ok;
  logic             john_ok;

  // Seeds, next-state shift and terminal-count detection for the registered mode
  always_comb begin
    mode_change = (mode != mode_q);
    seed_cur    = mode_q ? '0 : WIDTH'(1);
    seed_new    = mode   ? '0 : WIDTH'(1);
    nxt         = cnt_out;
    case ({mode_q, dir})
      2'b00:   nxt = {cnt_out[WIDTH-2:0], cnt_out[WIDTH-1]};
      2'b01:   nxt = {cnt_out[0], cnt_out[WIDTH-1:1]};
      2'b10:   nxt = {cnt_out[WIDTH-2:0], ~cnt_out[WIDTH-1]};
      default: nxt = {~cnt_out[0], cnt_out[WIDTH-1:1]};
    endcase
    step_tc = (nxt == seed_cur);
  end

  // Validity: ring wants one-hot; Johnson wants a run of ones anchored at either end
  always_comb begin
    ring_ok = (cnt_out != '0) && ((cnt_out & (cnt_out - WIDTH'(1))) == '0);
    john_ok = ((cnt_out & (cnt_out + WIDTH'(1))) == '0) ||
              ((~cnt_out & (~cnt_out + WIDTH'(1))) == '0);
    illegal = mode_q ? ~john_ok : ~ring_ok;
  end

  // State update: load beats mode resync beats stepping; tc only ever set by a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_out  <= WIDTH'(1);
      tc       <= 1'b0;
      wrap_cnt <= '0;
      mode_q   <= 1'b0;
    end else begin
      mode_q <= mode;
      if (load) begin
        cnt_out  <= load_val;
        tc       <= 1'b0;
        wrap_cnt <= '0;
      end else if (mode_change) begin
        cnt_out  <= seed_new;
        tc       <= 1'b0;
        wrap_cnt <= '0;
      end else if (en) begin
        if (SELF_CORRECT && illegal) begin
          cnt_out <= seed_cur;
          tc      <= 1'b0;
        end else begin
          cnt_out <= nxt;
          tc      <= step_tc;
          if (step_tc && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
          end
        end
      end else begin
        tc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb/tb_ring_johnson_counter.sv - directed vector bench for ring_johnson_counter
module tb_ring_johnson_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] cnt_out;
  logic       tc;
  logic [7:0] wrap_cnt;
  logic       illegal;
  logic [3:0] cnt_out2;
  logic       tc2;
  logic [1:0] wrap_cnt2;
  logic       illegal2;

  int total;
  int bad;

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       md;
    logic       dr;
    logic [3:0] c;
    logic       t;
    logic [7:0] w;
    logic       il;
  } vec_t;

  vec_t vq[$];

  ring_johnson_counter #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .cnt_out(cnt_out), .tc(tc),
    .wrap_cnt(wrap_cnt), .illegal(illegal)
  );

  ring_johnson_counter #(.WIDTH(4), .WRAP_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .cnt_out(cnt_out2), .tc(tc2),
    .wrap_cnt(wrap_cnt2), .illegal(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic ld, logic [3:0] lv, logic e, logic md, logic dr,
                              logic [3:0] c, logic t, logic [7:0] w, logic il);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = e; v.md = md; v.dr = dr;
    v.c = c; v.t = t; v.w = w; v.il = il;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0;

    // ring up, wrap, ring down
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0010, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0100, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b1000, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0001, 1, 1, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0010, 0, 1, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 4'b0001, 1, 2, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 4'b1000, 0, 2, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 1, 4'b0100, 0, 2, 0));
    // mode change with en=0 resyncs to Johnson seed
    vq.push_back(mk(0, 4'h0, 0, 1, 0, 4'b0000, 0, 0, 0));
    // Johnson up full period
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b0001, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b0011, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b0111, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b1110, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b1100, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b1000, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b0000, 1, 1, 0));
    // Johnson down
    vq.push_back(mk(0, 4'h0, 1, 1, 1, 4'b1000, 0, 1, 0));
    vq.push_back(mk(0, 4'h0, 1, 1, 1, 4'b1100, 0, 1, 0));
    // hold five cycles
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 4'h0, 0, 1, 1, 4'b1100, 0, 1, 0));
    // load together with mode change back to ring
    vq.push_back(mk(1, 4'b0011, 1, 0, 0, 4'b0011, 0, 0, 1));
`ifdef RING_SELF_CORRECT_EN
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0001, 0, 0, 0));
`else
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0110, 0, 0, 1));
`endif
    // load illegal ring pattern
    vq.push_back(mk(1, 4'b0101, 1, 0, 0, 4'b0101, 0, 0, 1));
`ifdef RING_SELF_CORRECT_EN
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0001, 0, 0, 0));
`else
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b1010, 0, 0, 1));
`endif
    vq.push_back(mk(1, 4'b1000, 0, 0, 0, 4'b1000, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0001, 1, 1, 0));
    // load illegal Johnson pattern while switching to Johnson
    vq.push_back(mk(1, 4'b0101, 0, 1, 0, 4'b0101, 0, 0, 1));
`ifdef RING_SELF_CORRECT_EN
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b0000, 0, 0, 0));
`else
    vq.push_back(mk(0, 4'h0, 1, 1, 0, 4'b1011, 0, 0, 1));
`endif
    // back to ring via load, then step
    vq.push_back(mk(1, 4'b0010, 0, 0, 0, 4'b0010, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0100, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b1000, 0, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0001, 1, 1, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 0, 4'b0010, 0, 1, 0));

    // reset state
    @(negedge clk);
    check("rst_cnt", 0, cnt_out, 4'b0001);
    check("rst_tc", 0, tc, 0);
    check("rst_wrap", 0, wrap_cnt, 0);
    check("rst_illegal", 0, illegal, 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      load = vq[i].ld; load_val = vq[i].lv; en = vq[i].en; mode = vq[i].md; dir = vq[i].dr;
      step();
      check("vec_cnt", i, cnt_out, vq[i].c);
      check("vec_tc", i, tc, vq[i].t);
      check("vec_wrap", i, wrap_cnt, vq[i].w);
      check("vec_illegal", i, illegal, vq[i].il);
    end
    load = 1'b0; en = 1'b0;

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("async_cnt", 0, cnt_out, 4'b0001);
    check("async_wrap", 0, wrap_cnt, 0);
    check("async_tc", 0, tc, 0);

    // release with mode=1: first edge resyncs to 0000
    @(negedge clk);
    mode = 1'b1; en = 1'b1; dir = 1'b0;
    rst_n = 1'b1;
    step();
    check("jrel_cnt", 0, cnt_out, 4'b0000);
    check("jrel_tc", 0, tc, 0);
    step();
    check("jrel_cnt", 1, cnt_out, 4'b0001);

    // saturating wrap counter on the WRAP_W=2 instance
    rst_n = 1'b0; mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("sat_cnt", k, cnt_out2, 4'b0001 << (k % 4));
      check("sat_tc", k, tc2, (k % 4) == 0);
      check("sat_wrap2", k, wrap_cnt2, (k / 4 > 3) ? 3 : k / 4);
    end
    check("sat_wrap8", 0, wrap_cnt, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
